// File: rtl/complex_div_seq_if.sv
// Operand/result bus of the sequential complex divider.
// Handshake rule for both directions: a transfer happens on the rising clock
// edge where valid and ready are both 1; the source holds its payload stable
// while valid is 1 and ready is 0, and ready never depends on valid.
interface complex_div_seq_if #(
  parameter int data_in_width  = 8,
  parameter int data_out_width = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [data_in_width-1:0]  a_real;
  logic [data_in_width-1:0]  a_imag;
  logic [data_in_width-1:0]  b_real;
  logic [data_in_width-1:0]  b_imag;
  logic                      out_valid;
  logic                      out_ready;
  logic [data_out_width-1:0] out_real;
  logic [data_out_width-1:0] out_imag;
  logic                      div_zero;
  logic                      sat;

  // Divider side
  modport slave (
    input  in_valid, a_real, a_imag, b_real, b_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, div_zero, sat
  );

  // Upstream/downstream side
  modport master (
    output in_valid, a_real, a_imag, b_real, b_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, div_zero, sat
  );
endinterface

// File: rtl/complex_div_seq.sv
// Sequential complex divider: q = a*conj(b) / |b|^2, quotient scaled by
// 2^frac_bits. Four multiply cycles build |b|^2 and the two numerators, then
// two restoring divisions (one quotient bit per cycle) produce the components.
module complex_div_seq #(
  parameter int data_in_width  = 8,
  parameter int data_out_width = 16,
  parameter int frac_bits      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  complex_div_seq_if.slave    bus,
  output logic [2:0]          dbg_state_o
);
  localparam int DIW   = data_in_width;
  localparam int DOW   = data_out_width;
  localparam int PW    = 2*DIW;              // product / |b|^2 width
  localparam int NW    = 2*DIW + 1;          // numerator width (signed)
  localparam int NUM_W = NW + frac_bits;     // dividend width = iterations
  localparam int CNT_W = $clog2(NUM_W + 1);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(NUM_W - 1);
  localparam logic [NUM_W-1:0] MAG_POS  = NUM_W'((64'd1 << (DOW-1)) - 64'd1);
  localparam logic [NUM_W-1:0] MAG_NEG  = NUM_W'(64'd1 << (DOW-1));

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_DIV_RE = 3'd2,
    S_DIV_IM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [DIW-1:0] ar_q, ai_q, br_q, bi_q;
  logic [PW-1:0]         den_q;
  logic signed [NW-1:0]  nr_q, ni_q;
  logic                  zero_q;
  logic [NUM_W-1:0]      div_n_q;   // dividend, shifted out MSB first
  logic [PW-1:0]         rem_q;     // partial remainder, always < den
  logic [NUM_W-1:0]      quo_q;     // quotient bits, shifted in LSB
  logic [NUM_W-1:0]      q_re_q;    // finished real magnitude

  logic                  out_valid_q;
  logic [DOW-1:0]        out_real_q, out_imag_q;
  logic                  div_zero_q, sat_q;

  // Shared multiplier lanes and the combined per-cycle term
  logic signed [DIW-1:0] mx0, my0, mx1, my1;
  logic signed [PW-1:0]  p0, p1;
  logic                  mul_sub;
  logic signed [NW-1:0]  term;

  // Restoring-division step
  logic [PW:0]           rem_sh, diff;
  logic                  fits;
  logic [PW-1:0]         rem_nx;
  logic [NUM_W-1:0]      quo_nx;

  // Numerator magnitudes
  logic [NW-1:0]         nr_mag, ni_mag;

  // Saturated results {sat, value}
  logic [DOW:0]          res_re, res_im;

  assign bus.in_ready  = reset_n && (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.sat       = sat_q;
  assign dbg_state_o   = state_q;

  // Clamp a sign/magnitude quotient into the signed output range
  function automatic logic [DOW:0] clamp(input logic neg, input logic [NUM_W-1:0] mag);
    logic [NUM_W-1:0] twos;
    twos = ~mag + NUM_W'(1);
    if (!neg) begin
      if (mag > MAG_POS) clamp = {1'b1, MAG_POS[DOW-1:0]};
      else               clamp = {1'b0, mag[DOW-1:0]};
    end else begin
      if (mag > MAG_NEG) clamp = {1'b1, MAG_NEG[DOW-1:0]};
      else               clamp = {1'b0, twos[DOW-1:0]};
    end
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and step counter
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_MUL;
      S_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) state_d = (den_q == '0) ? S_DONE : S_DIV_RE;
      end
      S_DIV_RE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) state_d = S_DIV_IM;
      end
      S_DIV_IM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) state_d = S_DONE;
      end
      S_DONE:   if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Operand select: squares of b first, then the real and imaginary numerators
  always_comb begin
    mx0 = '0; my0 = '0; mx1 = '0; my1 = '0; mul_sub = 1'b0;
    case (cnt_q[1:0])
      2'd0: begin mx0 = br_q; my0 = br_q; end
      2'd1: begin mx0 = bi_q; my0 = bi_q; end
      2'd2: begin mx0 = ar_q; my0 = br_q; mx1 = ai_q; my1 = bi_q; end
      default: begin mx0 = ai_q; my0 = br_q; mx1 = ar_q; my1 = bi_q; mul_sub = 1'b1; end
    endcase
    p0 = mx0 * my0;
    p1 = mx1 * my1;
    if (mul_sub) term = {p0[PW-1], p0} - {p1[PW-1], p1};
    else         term = {p0[PW-1], p0} + {p1[PW-1], p1};
  end

  // One restoring-division step and the magnitudes fed into it
  always_comb begin
    rem_sh = {rem_q, div_n_q[NUM_W-1]};
    diff   = rem_sh - {1'b0, den_q};
    fits   = ~diff[PW];                 // no borrow: divisor fits
    rem_nx = fits ? diff[PW-1:0] : rem_sh[PW-1:0];
    quo_nx = {quo_q[NUM_W-2:0], fits};
    nr_mag = nr_q[NW-1] ? NW'(-nr_q) : nr_q;
    ni_mag = ni_q[NW-1] ? NW'(-ni_q) : ni_q;
    res_re = clamp(nr_q[NW-1], q_re_q);
    res_im = clamp(ni_q[NW-1], quo_q);
  end

  // Datapath: operand capture, products, division and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
      den_q <= '0; nr_q <= '0; ni_q <= '0; zero_q <= 1'b0;
      div_n_q <= '0; rem_q <= '0; quo_q <= '0; q_re_q <= '0;
      out_valid_q <= 1'b0; out_real_q <= '0; out_imag_q <= '0;
      div_zero_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          ar_q <= bus.a_real; ai_q <= bus.a_imag;
          br_q <= bus.b_real; bi_q <= bus.b_imag;
          den_q <= '0;
          zero_q <= 1'b0;
        end
        S_MUL: begin
          case (cnt_q[1:0])
            2'd0: den_q <= p0;
            2'd1: den_q <= den_q + p0;
            2'd2: nr_q  <= term;
            default: begin
              ni_q    <= term;
              zero_q  <= (den_q == '0);
              div_n_q <= {nr_mag, {frac_bits{1'b0}}};
              rem_q   <= '0;
              quo_q   <= '0;
            end
          endcase
        end
        S_DIV_RE: begin
          if (cnt_q == DIV_LAST) begin
            q_re_q  <= quo_nx;
            div_n_q <= {ni_mag, {frac_bits{1'b0}}};
            rem_q   <= '0;
            quo_q   <= '0;
          end else begin
            div_n_q <= {div_n_q[NUM_W-2:0], 1'b0};
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
          end
        end
        S_DIV_IM: begin
          div_n_q <= {div_n_q[NUM_W-2:0], 1'b0};
          rem_q   <= rem_nx;
          quo_q   <= quo_nx;
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            if (zero_q) begin
              out_real_q <= '0; out_imag_q <= '0;
              div_zero_q <= 1'b1; sat_q <= 1'b0;
            end else begin
              out_real_q <= res_re[DOW-1:0];
              out_imag_q <= res_im[DOW-1:0];
              div_zero_q <= 1'b0;
              sat_q      <= res_re[DOW] | res_im[DOW];
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_div_seq.sv
// Directed bench for complex_div_seq with hand-computed quotients.
module tb_complex_div_seq;
  logic       clk;
  logic       reset_n;
  logic [2:0] dbg_state;
  int         vectors;
  int         miscompares;

  complex_div_seq_if #(.data_in_width(8), .data_out_width(16)) bus ();

  complex_div_seq #(
    .data_in_width(8), .data_out_width(16), .frac_bits(8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_operands();
    bus.a_real = 8'($urandom_range(0, 255));
    bus.a_imag = 8'($urandom_range(0, 255));
    bus.b_real = 8'($urandom_range(0, 255));
    bus.b_imag = 8'($urandom_range(0, 255));
  endtask

  // Issue one operation, check latency and result, optionally stall, then drain
  task automatic run_op(input string tag, input int ar, input int ai, input int br, input int bi,
                        input int e_re, input int e_im, input int e_dz, input int e_sat,
                        input int e_lat, input int hold);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    bus.a_real = 8'(ar); bus.a_imag = 8'(ai);
    bus.b_real = 8'(br); bus.b_imag = 8'(bi);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_operands();
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk({tag, "_latency"}, cyc, e_lat);
    chk({tag, "_re"}, int'($signed(bus.out_real)), e_re);
    chk({tag, "_im"}, int'($signed(bus.out_imag)), e_im);
    chk({tag, "_div_zero"}, int'(bus.div_zero), e_dz);
    chk({tag, "_sat"}, int'(bus.sat), e_sat);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      scramble_operands();
      @(negedge clk);
      chk({tag, "_stall"},
          int'(bus.out_valid && !bus.in_ready &&
               $signed(bus.out_real) == 16'(e_re) && $signed(bus.out_imag) == 16'(e_im) &&
               bus.div_zero == 1'(e_dz) && bus.sat == 1'(e_sat)), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, int'(bus.out_valid), 0);
    chk({tag, "_ready_again"}, int'(bus.in_ready), 1);
    chk({tag, "_re_held"}, int'($signed(bus.out_real)), e_re);
  endtask

  initial begin
    int cyc;
    int seen;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_real = '0; bus.a_imag = '0; bus.b_real = '0; bus.b_imag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out", int'({bus.out_real, bus.out_imag}), 0);
    chk("rst_flags", int'({bus.div_zero, bus.sat}), 0);
    chk("rst_state", int'(dbg_state), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // Directed vectors
    run_op("v1",    3,   4,  1,  2,   563,  -102, 0, 0, 55, 0);
    run_op("v2",  100,   0,  2,  0, 12800,     0, 0, 0, 55, 0);
    run_op("v3", -100,  50,  0, -5, -2560, -5120, 0, 0, 55, 0);
    run_op("dz",    5,   5,  0,  0,     0,     0, 1, 0,  5, 0);
    run_op("satp",-128,  0, -1,  0, 32767,     0, 0, 1, 55, 0);
    run_op("stall",  3,  4,  1,  2,   563,  -102, 0, 0, 55, 20);
    run_op("satn", 127,  0, -1,  0,  -32512,   0, 0, 0, 55, 0);
    run_op("sat2",-128,-128, 1,  0, -32768, -32768, 0, 0, 55, 0);

    // Leave a saturated result on the outputs, then abort an op during DIV_RE
    run_op("presat",-128, 0, -1,  0, 32767,     0, 0, 1, 55, 0);
    bus.a_real = 8'(3); bus.a_imag = 8'(4); bus.b_real = 8'(1); bus.b_imag = 8'(2);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_in_div_re", int'(dbg_state), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_out", int'({bus.out_real, bus.out_imag}), 0);
    chk("abort_flags", int'({bus.div_zero, bus.sat}), 0);
    chk("abort_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("abort_no_out_valid", seen, 0);
    run_op("after_rst", 3, 4, 1, 2, 563, -102, 0, 0, 55, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
